// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Multiply-class ops hold busy for MUL_CYCLES cycles. Divide-class ops run
// a restoring divider for WIDTH cycles, then take one sign-fixup cycle.
// HI/LO are written only on a completion edge or an idle MTHI/MTLO edge.
// Build option: define MULDIV_MADD_EN to turn ops 4-7 into accumulate
// (MADD/MADDU) and subtract (MSUB/MSUBU) operations on {hi,lo}. When it is
// not defined, those ops behave as MULT/MULTU.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // The counter has to reach the longer of the two iteration counts.
    localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Absolute value for signed ops; the raw bits for unsigned ops.
    // The most-negative value maps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    // Full 2*WIDTH product. Both operands are extended to 2*WIDTH, so the
    // truncated signed product is exact.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic signed [2*WIDTH-1:0] ea;
        logic signed [2*WIDTH-1:0] eb;
        ea = sgn ? $signed({{WIDTH{a[WIDTH-1]}}, a}) : $signed({{WIDTH{1'b0}}, a});
        eb = sgn ? $signed({{WIDTH{b[WIDTH-1]}}, b}) : $signed({{WIDTH{1'b0}}, b});
        return ea * eb;
    endfunction

    // Final {hi, lo} from the unsigned quotient and remainder magnitudes.
    // Divide by zero and signed overflow are handled explicitly.
    function automatic logic [2*WIDTH-1:0] div_fix(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] r,
                                                   input logic             sgn);
        logic [WIDTH-1:0] qq;
        logic [WIDTH-1:0] rr;
        if (b == '0) begin
            qq = ALL_ONES;
            rr = a;
        end else if (sgn && (a == MOST_NEG) && (b == ALL_ONES)) begin
            qq = MOST_NEG;
            rr = '0;
        end else begin
            qq = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? negate(q) : q;
            rr = (sgn && a[WIDTH-1]) ? negate(r) : r;
        end
        return {rr, qq};
    endfunction

    logic [1:0]       state_q, state_d;
    logic             busy_q,  busy_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             sgn_q,   sgn_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
`ifdef MULDIV_MADD_EN
    logic             acc_q,   acc_d;
    logic             sub_q,   sub_d;
`endif

    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH:0]     rem_sh;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mul_res;

    // Next-state logic: FSM sequencing, divider step, result commit and MTHI/MTLO.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_MADD_EN
        acc_d   = acc_q;
        sub_d   = sub_q;
`endif

        dvs_mag = magnitude(b_q, sgn_q);
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        product = mul_full(a_q, b_q, sgn_q);
        mul_res = product;
`ifdef MULDIV_MADD_EN
        if (acc_q) begin
            mul_res = sub_q ? ({hi_q, lo_q} - product) : ({hi_q, lo_q} + product);
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!cancel) begin
                        a_d    = src_a;
                        b_d    = src_b;
                        sgn_d  = ~op[0];
                        cnt_d  = '0;
                        busy_d = 1'b1;
`ifdef MULDIV_MADD_EN
                        acc_d  = op[2];
                        sub_d  = op[1];
`endif
                        if (op[2:1] == 2'b01) begin
                            state_d = ST_DIV;
                            quo_d   = magnitude(src_a, ~op[0]);
                            rem_d   = '0;
                        end else begin
                            state_d = ST_MUL;
                        end
                    end
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == MUL_LAST) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    // Restoring step: shift the next dividend bit in and subtract when it fits.
                    if (rem_sh >= {1'b0, dvs_mag}) begin
                        rem_d = rem_sh[WIDTH-1:0] - dvs_mag;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == DIV_LAST) begin
                        state_d = ST_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FIX: begin
                if (!cancel) begin
                    {hi_d, lo_d} = div_fix(a_q, b_q, quo_q, rem_q, sgn_q);
                end
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; the asynchronous reset clears control and datapath alike.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_MADD_EN
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_MADD_EN
            acc_q   <= acc_d;
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32, MUL_CYCLES=5): directed cases plus
// randomized operations checked against a behavioural HI/LO model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of one operation's effect on HI/LO.
    task automatic model_exec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] acc;
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        if (o == 3'd2 || o == 3'd3) begin
            if (b == 32'd0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = a;
            end else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                m_lo = 32'h8000_0000;
                m_hi = 32'd0;
            end else if (o == 3'd2) begin
                ia = a;
                ib = b;
                m_lo = ia / ib;
                m_hi = ia % ib;
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
        end else begin
            if (o[0] == 1'b0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            acc = {m_hi, m_lo};
`ifdef MULDIV_MADD_EN
            if (o == 3'd4 || o == 3'd5) acc = acc + p;
            else if (o == 3'd6 || o == 3'd7) acc = acc - p;
            else acc = p;
`else
            acc = p;
`endif
            {m_hi, m_lo} = acc;
        end
    endtask

    // mode: 0 plain, 1 MTHI/MTLO during busy, 2 second start during busy,
    // 3 lo_we asserted together with start.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
        int          cyc;
        int          exp_len;
        logic [31:0] ph;
        logic [31:0] pl;
        ph = m_hi;
        pl = m_lo;
        op = o; src_a = a; src_b = b; start = 1'b1;
        if (mode == 3) begin
            lo_we = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        check_val("hold_hi", hi, ph);
        check_val("hold_lo", lo, pl);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == 2 && mode == 1) begin
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
            end else if (cyc == 2 && mode == 2) begin
                start = 1'b1; op = 3'd1; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
            end else begin
                hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
            end
            @(posedge clk); #1;
        end
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        model_exec(o, a, b);
        exp_len = (o == 3'd2 || o == 3'd3) ? 33 : 5;
        check_val("busy_len", cyc, exp_len);
        check_val("res_hi", hi, m_hi);
        check_val("res_lo", lo, m_lo);
    endtask

    task automatic mt_write(input logic w_hi, input logic w_lo, input logic [31:0] d);
        hi_we = w_hi; lo_we = w_lo; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (w_hi) m_hi = d;
        if (w_lo) m_lo = d;
        check_val("mt_hi", hi, m_hi);
        check_val("mt_lo", lo, m_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic cases.
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        check_val("mult_k_hi", hi, 32'hFFFF_FFFF);
        check_val("mult_k_lo", lo, 32'hFFFF_FFEB);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        check_val("multu_k", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check_val("div_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd0, 0);
        check_val("divu0_k", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_val("divovf_k", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'd100, 32'hFFFF_FFF9, 0);

        // MTHI / MTLO, and writes that must be ignored.
        mt_write(1'b1, 1'b0, 32'h1234);
        mt_write(1'b0, 1'b1, 32'h5678);
        check_val("mt_k", {hi, lo}, 64'h0000_1234_0000_5678);
        mt_write(1'b1, 1'b1, 32'hCAFE_0001);
        run_op(3'd0, 32'd9, 32'd9, 1);
        run_op(3'd3, 32'd1000, 32'd7, 1);
        run_op(3'd1, 32'd12, 32'd13, 3);

        // Back-to-back: DIVU then MULT with no bubble, second start ignored.
        run_op(3'd3, 32'hFFFF_0000, 32'd3, 0);
        run_op(3'd0, 32'd5, 32'hFFFF_FFFE, 2);

        // Cancel mid-divide, then a normal MULT right away.
        op = 3'd2; src_a = 32'd12345; src_b = 32'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check_val("cancel_pre_busy", busy, 1'b1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check_val("cancel_busy", busy, 1'b0);
        check_val("cancel_hi", hi, m_hi);
        check_val("cancel_lo", lo, m_lo);
        run_op(3'd0, 32'd6, 32'd7, 0);

        // Asynchronous reset in the middle of a divide.
        mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
        op = 3'd2; src_a = 32'd999; src_b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_hi", hi, 32'd0);
        check_val("arst_lo", lo, 32'd0);
        #2;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        check_val("arst_idle", busy, 1'b0);

        // Accumulate-class ops (model follows the build option).
        mt_write(1'b1, 1'b0, 32'd0);
        mt_write(1'b0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd1, 32'd1, 0);
`ifdef MULDIV_MADD_EN
        check_val("maddu_k", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        check_val("maddu_k", {hi, lo}, 64'h0000_0000_0000_0001);
`endif
        mt_write(1'b1, 1'b1, 32'd0);
        run_op(3'd6, 32'd2, 32'd3, 0);
`ifdef MULDIV_MADD_EN
        check_val("msub_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
`else
        check_val("msub_k", {hi, lo}, 64'h0000_0000_0000_0006);
`endif
        run_op(3'd4, 32'hFFFF_FFFF, 32'd5, 0);
        run_op(3'd7, 32'h8000_0000, 32'd3, 0);

        // Randomized mix of operations and register writes.
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
                run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                       ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined CPU's execute stage. It accepts one operation per start pulse, holds `busy` while computing, and commits the result to HI/LO atomically on completion. It succeeds the fixed 32-bit unit with:
- a configurable datapath width and multiply latency;
- a true iterative restoring divider;
- a pipeline-flush cancel input;
- defined divide-by-zero and overflow results;
- optional accumulate operations.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width (≥ 4).
- `MUL_CYCLES`, 5, cycles `busy` stays high for multiply-class ops (≥ 1).

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  launch operation `op` on `src_a`/`src_b` (honoured only when idle).
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `src_a`  in  WIDTH  multiplicand / dividend.
- `src_b`  in  WIDTH  multiplier / divisor.
- `cancel`  in  1  abort in-flight operation (exception flush).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `hi`  out  WIDTH  HI register (MFHI source).
- `lo`  out  WIDTH  LO register (MFLO source).

## Operation
- Reset values:
  - `busy` = 0, `hi` = 0, `lo` = 0.
  - FSM in IDLE.
  - Internal operand, counter and partial-remainder registers cleared.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - `start` = 1 with `cancel` = 0 latches `src_a`, `src_b` and `op`.
  - ops 0/1/4–7 go to MUL; ops 2/3 go to DIV.
  - `start` with `cancel` = 1 is ignored.
- MUL:
  - The counter runs `MUL_CYCLES` cycles.
  - On the last cycle the 2·WIDTH product is computed: signed for 0/4/6, unsigned for 1/5/7.
  - MULT/MULTU: {hi,lo} = product.
  - MADD*: {hi,lo} += product. MSUB*: {hi,lo} −= product. Arithmetic is modulo 2^(2·WIDTH).
  - FSM returns to IDLE.
- DIV:
  - Restoring divider on operand magnitudes (signed op) or raw values (unsigned op).
  - One quotient bit per cycle for WIDTH cycles, then FIX.
- FIX:
  - Sign correction: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Writes lo = quotient, hi = remainder, then returns to IDLE.
- Divide by zero: lo = all ones, hi = `src_a`. No trap.
- Signed overflow (most-negative ÷ −1): lo = most-negative, hi = 0.
- `start` while busy: ignored.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE and only when `start` = 0; `start` has priority and the write is dropped.
  - Both may be asserted together, writing `wdata` to both registers.
- `cancel` while busy:
  - FSM goes to IDLE on the next edge; hi/lo remain unchanged.
  - `busy` deasserts on that edge.
- Reset mid-operation: everything clears; no partial result is written.

## Timing
- Start edge T: `busy` = 1 from T+1.
- Multiply class: result in hi/lo and `busy` = 0 after edge T+`MUL_CYCLES`. `busy` is high for exactly `MUL_CYCLES` cycles.
- Divide class: `busy` is high for exactly WIDTH+1 cycles (WIDTH DIV + 1 FIX). Result is visible after edge T+WIDTH+1.
- hi/lo change only on the completion edge or an IDLE write edge. They are never updated partially.
- A new `start` is accepted in the same cycle `busy` first reads 0 (back-to-back, zero bubble).
- MTHI/MTLO write at edge T is visible on `hi`/`lo` from T+1.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_MADD_EN` defined:
  - ops 4–7 perform the accumulate/subtract operations described above.
- Not defined:
  - ops 4–7 behave exactly as op 0 (MULT) for 4 and 6, and as op 1 (MULTU) for 5 and 7.
  - The accumulate adder is not synthesised.

## Test plan
- WIDTH=32, MULT −3 × 7 → `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF × 2 → hi=1, lo=0xFFFFFFFE.
- DIV −7 ÷ 2 → `busy` high 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 ÷ 0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000 ÷ −1 → lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 in IDLE → hi=0x1234, lo=0x5678 next cycle. Both writes asserted during `busy` → ignored. `start` with `lo_we` in IDLE → write dropped.
- DIV started, `cancel` at cycle 10 → `busy` = 0 next edge, hi/lo keep prior values. New MULT issued the next cycle completes normally. Async `reset` mid-DIV → outputs 0 immediately.
- With `MULDIV_MADD_EN`: hi=0, lo=0xFFFFFFFF, MADDU 1 × 1 → hi=1, lo=0. MSUB 2 × 3 from {0,0} → hi=0xFFFFFFFF, lo=0xFFFFFFFA. Without the macro the same MADDU gives hi=0, lo=1.
- Back-to-back: MULT accepted the cycle `busy` falls after a DIVU. Second `start` during `busy` is ignored, and the result matches the first op only.
